// File: rtl/spi_signal_tx.sv
// rtl/spi_signal_tx.sv - SPI mode-0 slave transmitter returning six signal bytes to the MCU
module spi_signal_tx #(
    parameter int NBYTES      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] sd0,
    input  logic [7:0] sd1,
    input  logic [7:0] sd2,
    input  logic [7:0] sd3,
    input  logic [7:0] sd4,
    input  logic [7:0] sd5,
    input  logic       load,
    input  logic       sck,
    input  logic       cs_n,
    output logic       miso,
    output logic       tx_busy,
    output logic       frame_done,
    output logic       frame_abort,
    output logic       data_fresh
);

    localparam int FW = 8 * NBYTES;
    localparam int CW = $clog2(FW + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // sd0 lands in the top byte so the first bit on the wire is sd0[7]
    logic [47:0] frame_in;
    assign frame_in = {sd0, sd1, sd2, sd3, sd4, sd5};

    // Synchronizer chains plus one history flop each for edge detection
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q, cs_prev_d;

    logic [FW-1:0] holding_q, holding_d;
    logic [FW-1:0] shift_q, shift_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic          miso_q, miso_d;
    logic          tx_busy_q, tx_busy_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_abort_q, frame_abort_d;
    logic          data_fresh_q, data_fresh_d;

    logic sck_s, cs_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;

    // Next-state logic: synchronizers, holding register and frame sequencing
    always_comb begin
        sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], sck};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        sck_prev_d    = sck_s;
        cs_prev_d     = cs_s;
        holding_d     = holding_q;
        shift_d       = shift_q;
        count_d       = count_q;
        state_d       = state_q;
        tx_busy_d     = tx_busy_q;
        data_fresh_d  = data_fresh_q;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;

        // Loads only ever touch the holding register; an active frame keeps its snapshot
        if (load) begin
            holding_d    = FW'(frame_in);
            data_fresh_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    // Snapshot the pre-load holding value; a coincident load stays fresh
                    shift_d   = holding_q;
                    count_d   = '0;
                    tx_busy_d = 1'b1;
                    state_d   = ST_SHIFT;
                    if (!load) begin
                        data_fresh_d = 1'b0;
                    end
                end
            end
            ST_SHIFT: begin
                // cs_n has priority over a coincident sck edge
                if (cs_rise) begin
                    frame_abort_d = 1'b1;
                    tx_busy_d     = 1'b0;
                    shift_d       = '0;
                    count_d       = '0;
                    state_d       = ST_IDLE;
                end else if (sck_rise) begin
                    count_d = (count_q == CW'(FW)) ? count_q : count_q + CW'(1);
                    if (count_q == CW'(FW - 1)) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_DONE;
                    end
                end else if (sck_fall && (count_q != '0)) begin
                    // A fall before the first rise is the idle level settling, not a bit boundary
                    shift_d = {shift_q[FW-2:0], 1'b0};
                end
            end
            ST_DONE: begin
                if (cs_rise) begin
                    tx_busy_d = 1'b0;
                    count_d   = '0;
                    state_d   = ST_IDLE;
                end else if (sck_fall) begin
                    // Drains the last bit so the register ends the frame all zero
                    shift_d = {shift_q[FW-2:0], 1'b0};
                end
            end
            default: begin
                state_d   = ST_IDLE;
                tx_busy_d = 1'b0;
            end
        endcase

        // miso mirrors the shift MSB only while shifting; zero otherwise
        miso_d = (state_d == ST_SHIFT) ? shift_d[FW-1] : 1'b0;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q    <= '0;
            cs_sync_q     <= '1;
            sck_prev_q    <= 1'b0;
            cs_prev_q     <= 1'b1;
            holding_q     <= '0;
            shift_q       <= '0;
            count_q       <= '0;
            state_q       <= ST_IDLE;
            miso_q        <= 1'b0;
            tx_busy_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            data_fresh_q  <= 1'b0;
        end else begin
            sck_sync_q    <= sck_sync_d;
            cs_sync_q     <= cs_sync_d;
            sck_prev_q    <= sck_prev_d;
            cs_prev_q     <= cs_prev_d;
            holding_q     <= holding_d;
            shift_q       <= shift_d;
            count_q       <= count_d;
            state_q       <= state_d;
            miso_q        <= miso_d;
            tx_busy_q     <= tx_busy_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
            data_fresh_q  <= data_fresh_d;
        end
    end

    assign miso        = miso_q;
    assign tx_busy     = tx_busy_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;
    assign data_fresh  = data_fresh_q;

endmodule

// File: tb/tb_spi_signal_tx.sv
// tb/tb_spi_signal_tx.sv - self-checking bench for spi_signal_tx with an MCU-side SPI reader
module tb_spi_signal_tx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] sd0 = 8'h0, sd1 = 8'h0, sd2 = 8'h0, sd3 = 8'h0, sd4 = 8'h0, sd5 = 8'h0;
    logic       load = 1'b0;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       miso, tx_busy, frame_done, frame_abort, data_fresh;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    logic [63:0] exp_q[$];

    spi_signal_tx #(.NBYTES(6), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .sd0(sd0), .sd1(sd1), .sd2(sd2), .sd3(sd3), .sd4(sd4), .sd5(sd5),
        .load(load), .sck(sck), .cs_n(cs_n),
        .miso(miso), .tx_busy(tx_busy), .frame_done(frame_done),
        .frame_abort(frame_abort), .data_fresh(data_fresh)
    );

    always #5 clk = ~clk;

    // Pulse monitors: a one-cycle pulse adds exactly one to its counter
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (frame_abort === 1'b1) abort_cnt++;
    end

    task automatic do_load(input logic [47:0] val);
        @(negedge clk);
        {sd0, sd1, sd2, sd3, sd4, sd5} = val;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // MCU side of a mode-0 read: sample miso just before each sck rise, 10 clk per phase
    task automatic run_frame(input int nbits, input int abort_after, input int load_at,
                             input logic [47:0] load_val, input int reset_at,
                             output logic [63:0] rx, output logic busy_mid, output logic df_mid);
        rx = '0;
        busy_mid = 1'b0;
        df_mid = 1'b0;
        @(negedge clk);
        cs_n = 1'b0;
        for (int i = 0; i < nbits && i != abort_after; i++) begin
            if (i == load_at) do_load(load_val);
            if (i == reset_at) begin
                reset_n = 1'b0;
                #1;
                checks++;
                if ({miso, tx_busy, frame_done, frame_abort, data_fresh} !== 5'b0) begin
                    errors++;
                    $display("FAIL reset_mid_outputs: got %b want 00000",
                             {miso, tx_busy, frame_done, frame_abort, data_fresh});
                end
            end
            repeat (10) @(negedge clk);
            if (i == nbits / 2) begin
                busy_mid = tx_busy;
                df_mid = data_fresh;
            end
            rx = {rx[62:0], miso};
            sck = 1'b1;
            repeat (10) @(negedge clk);
            sck = 1'b0;
        end
        repeat (10) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({miso, tx_busy, frame_done, frame_abort, data_fresh} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {miso, tx_busy, frame_done, frame_abort, data_fresh});
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_idle_no_load();
        logic [63:0] rx, e;
        logic bm, dm;
        int d0;
        d0 = done_cnt;
        exp_q.push_back(64'h0);
        run_frame(48, -1, -1, 48'h0, -1, rx, bm, dm);
        e = exp_q.pop_front();
        checks++;
        if (rx !== e) begin errors++; $display("FAIL idle_frame: got %h want %h", rx, e); end
        checks++;
        if (dm !== 1'b0 || data_fresh !== 1'b0) begin
            errors++; $display("FAIL idle_data_fresh: got %b/%b want 0/0", dm, data_fresh);
        end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL idle_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_basic();
        logic [63:0] rx, e;
        logic bm, dm;
        int d0;
        do_load(48'h5566778899AA);
        checks++;
        if (data_fresh !== 1'b1) begin errors++; $display("FAIL basic_fresh_after_load: got %b want 1", data_fresh); end
        d0 = done_cnt;
        exp_q.push_back(64'h0000_5566778899AA);
        run_frame(48, -1, -1, 48'h0, -1, rx, bm, dm);
        e = exp_q.pop_front();
        checks++;
        if (rx !== e) begin errors++; $display("FAIL basic_frame: got %h want %h", rx, e); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done: got %0d want 1", done_cnt - d0); end
        checks++;
        if (bm !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b want 1", bm); end
        checks++;
        if (dm !== 1'b0) begin errors++; $display("FAIL basic_fresh_mid: got %b want 0", dm); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", tx_busy); end
    endtask

    task automatic test_load_during_frame();
        logic [63:0] rx, e;
        logic bm, dm;
        do_load(48'h5566778899AA);
        exp_q.push_back(64'h0000_5566778899AA);
        run_frame(48, -1, 20, 48'h112233445566, -1, rx, bm, dm);
        e = exp_q.pop_front();
        checks++;
        if (rx !== e) begin errors++; $display("FAIL ldf_current_frame: got %h want %h", rx, e); end
        checks++;
        if (dm !== 1'b1 || data_fresh !== 1'b1) begin
            errors++; $display("FAIL ldf_fresh_between: got %b/%b want 1/1", dm, data_fresh);
        end
        exp_q.push_back(64'h0000_112233445566);
        run_frame(48, -1, -1, 48'h0, -1, rx, bm, dm);
        e = exp_q.pop_front();
        checks++;
        if (rx !== e) begin errors++; $display("FAIL ldf_next_frame: got %h want %h", rx, e); end
    endtask

    task automatic test_abort();
        logic [63:0] rx, e;
        logic bm, dm;
        int d0, a0;
        d0 = done_cnt;
        a0 = abort_cnt;
        run_frame(48, 17, -1, 48'h0, -1, rx, bm, dm);
        checks++;
        if (abort_cnt - a0 != 1) begin errors++; $display("FAIL abort_pulse: got %0d want 1", abort_cnt - a0); end
        checks++;
        if (done_cnt - d0 != 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); end
        checks++;
        if (miso !== 1'b0 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL abort_idle_outputs: got miso=%b busy=%b want 0/0", miso, tx_busy);
        end
        exp_q.push_back(64'h0000_112233445566);
        run_frame(48, -1, -1, 48'h0, -1, rx, bm, dm);
        e = exp_q.pop_front();
        checks++;
        if (rx !== e) begin errors++; $display("FAIL abort_then_frame: got %h want %h", rx, e); end
    endtask

    task automatic test_overclock();
        logic [63:0] rx, e;
        logic bm, dm;
        int d0;
        do_load(48'hC3A55A3C0FF0);
        d0 = done_cnt;
        exp_q.push_back({12'h0, 48'hC3A55A3C0FF0, 4'h0});
        run_frame(52, -1, -1, 48'h0, -1, rx, bm, dm);
        e = exp_q.pop_front();
        checks++;
        if (rx !== e) begin errors++; $display("FAIL overclock_frame: got %h want %h", rx, e); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL overclock_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] rx, e;
        logic bm, dm;
        int d0;
        do_load(48'h0123456789AB);
        d0 = done_cnt;
        run_frame(48, -1, -1, 48'h0, 30, rx, bm, dm);
        checks++;
        if (done_cnt - d0 != 0) begin errors++; $display("FAIL resetmid_no_done: got %0d want 0", done_cnt - d0); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        do_load(48'hFFFFFFFFFFFF);
        d0 = done_cnt;
        exp_q.push_back(64'h0000_FFFFFFFFFFFF);
        run_frame(48, -1, -1, 48'h0, -1, rx, bm, dm);
        e = exp_q.pop_front();
        checks++;
        if (rx !== e) begin errors++; $display("FAIL resetmid_next_frame: got %h want %h", rx, e); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL resetmid_next_done: got %0d want 1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_idle_no_load();
        test_basic();
        test_load_during_frame();
        test_abort();
        test_overclock();
        test_reset_mid_frame();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
